// File: rtl/obstacle_scroller_if.sv
// Bundle between the game controller and the obstacle scroller.
// The controller (master) supplies enable/speed and consumes the obstacle
// positions, pass pulses and score produced by the scroller (slave).
interface obstacle_scroller_if #(
    parameter int N_OBS = 3,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
) ();
    logic                   enable;
    logic [1:0]             speed;
    logic [N_OBS*X_W-1:0]   obs_x;
    logic [N_OBS*Y_W-1:0]   obs_y;
    logic [N_OBS-1:0]       obs_active;
    logic [N_OBS-1:0]       passed;
    logic [15:0]            score;

    modport master (
        output enable, speed,
        input  obs_x, obs_y, obs_active, passed, score
    );

    modport slave (
        input  enable, speed,
        output obs_x, obs_y, obs_active, passed, score
    );
endinterface

// File: rtl/obstacle_scroller.sv
// Multi-obstacle scroller for the runner game.
// Moves N_OBS obstacles leftwards one step per enabled game tick, retires
// those that leave the left edge and respawns them off-screen right with an
// LFSR-chosen gap and height, keeping a minimum spacing behind the rearmost
// active obstacle. Every output comes straight from a register.
module obstacle_scroller #(
    parameter int         N_OBS       = 3,
    parameter int         X_W         = 8,
    parameter int         Y_W         = 7,
    parameter int         SCREEN_W    = 160,
    parameter int         GROUND_Y    = 100,
    parameter int         JUMP_DY     = 15,
    parameter int         MAX_GAP     = 31,
    parameter int         MIN_SPACING = 40,
    parameter logic [7:0] LFSR_SEED   = 8'h9D
) (
    input  logic               slowed_clock,
    input  logic               rst_n,
    obstacle_scroller_if.slave bus
);

    localparam logic [X_W-1:0] SPAWN_BASE  = X_W'(SCREEN_W);
    localparam logic [X_W-1:0] SPAWN_LIMIT = X_W'(SCREEN_W - MIN_SPACING);
    localparam logic [Y_W-1:0] Y_GROUND    = Y_W'(GROUND_Y);
    localparam logic [Y_W-1:0] Y_AIR       = Y_W'(GROUND_Y - JUMP_DY);
    localparam logic [7:0]     GAP_MASK    = 8'(MAX_GAP);

    logic [7:0]           lfsr_q, lfsr_d, lfsr_next;
    logic [N_OBS*X_W-1:0] x_q, x_d;
    logic [N_OBS*Y_W-1:0] y_q, y_d;
    logic [N_OBS-1:0]     active_q, active_d;
    logic [N_OBS-1:0]     passed_q, passed_d;
    logic [15:0]          score_q, score_d;

    logic [X_W-1:0]       step;
    logic [X_W-1:0]       gap;
    logic [X_W-1:0]       cur_x;
    logic                 spawn_ok;
    logic                 free_seen;
    logic [N_OBS-1:0]     spawn_sel;
    logic [16:0]          score_sum;

    assign step      = X_W'(bus.speed) + X_W'(1);
    assign gap       = X_W'(lfsr_q & GAP_MASK);
    assign lfsr_next = {lfsr_q[6],
                        lfsr_q[5] ^ lfsr_q[7],
                        lfsr_q[4] ^ lfsr_q[7],
                        lfsr_q[3] ^ lfsr_q[7],
                        lfsr_q[2:0],
                        lfsr_q[7]};

    // Spawn decode: pick the lowest free channel and block spawning while any
    // active obstacle (retiring ones included) is still too close to the right edge.
    always_comb begin
        spawn_ok  = 1'b1;
        spawn_sel = '0;
        free_seen = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            if (active_q[i] && (x_q[i*X_W +: X_W] > SPAWN_LIMIT)) begin
                spawn_ok = 1'b0;
            end
            spawn_sel[i] = !active_q[i] && !free_seen;
            if (!active_q[i]) begin
                free_seen = 1'b1;
            end
        end
    end

    // Next-state: move or retire active obstacles, spawn into the chosen free
    // channel, advance the LFSR and accumulate the saturating score.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        active_d  = active_q;
        passed_d  = '0;
        score_d   = score_q;
        lfsr_d    = lfsr_q;
        score_sum = '0;
        cur_x     = '0;
        if (bus.enable) begin
            lfsr_d = lfsr_next;
            for (int i = 0; i < N_OBS; i++) begin
                cur_x = x_q[i*X_W +: X_W];
                if (active_q[i]) begin
                    if (cur_x > step) begin
                        x_d[i*X_W +: X_W] = cur_x - step;
                    end else begin
                        active_d[i] = 1'b0;
                        passed_d[i] = 1'b1;
                    end
                end else if (spawn_sel[i] && spawn_ok) begin
                    active_d[i]       = 1'b1;
                    x_d[i*X_W +: X_W] = SPAWN_BASE + gap;
                    y_d[i*Y_W +: Y_W] = lfsr_q[7] ? Y_AIR : Y_GROUND;
                end
            end
            score_sum = {1'b0, score_q};
            for (int i = 0; i < N_OBS; i++) begin
                score_sum = score_sum + 17'(passed_d[i]);
            end
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge slowed_clock or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q   <= LFSR_SEED;
            x_q      <= '0;
            y_q      <= {N_OBS{Y_GROUND}};
            active_q <= '0;
            passed_q <= '0;
            score_q  <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
            passed_q <= passed_d;
            score_q  <= score_d;
        end
    end

    assign bus.obs_x      = x_q;
    assign bus.obs_y      = y_q;
    assign bus.obs_active = active_q;
    assign bus.passed     = passed_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller: a behavioural model predicts every
// edge, predictions are queued when the stimulus is applied and compared once
// the DUT has produced its registered outputs.
module tb_obstacle_scroller;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;

    typedef struct {
        logic [N*XW-1:0] x;
        logic [N*YW-1:0] y;
        logic [N-1:0]    a;
        logic [N-1:0]    p;
        logic [15:0]     s;
    } snap_t;

    logic slowed_clock = 1'b0;
    logic rst_n        = 1'b0;

    int total = 0;
    int bad   = 0;

    snap_t sb[$];

    int         m_x[N];
    int         m_y[N];
    bit         m_act[N];
    bit         m_pass[N];
    int         m_score;
    logic [7:0] m_lfsr;

    obstacle_scroller_if #(.N_OBS(N), .X_W(XW), .Y_W(YW)) bus ();

    obstacle_scroller #(.N_OBS(N), .X_W(XW), .Y_W(YW)) dut (
        .slowed_clock (slowed_clock),
        .rst_n        (rst_n),
        .bus          (bus)
    );

    always #5 slowed_clock = ~slowed_clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i]    = 0;
            m_y[i]    = 100;
            m_act[i]  = 1'b0;
            m_pass[i] = 1'b0;
        end
        m_score = 0;
        m_lfsr  = 8'h9D;
    endtask

    task automatic model_edge(input logic en, input logic [1:0] spd);
        int         step;
        int         tgt;
        int         nret;
        bit         ok;
        logic [7:0] r;
        for (int i = 0; i < N; i++) m_pass[i] = 1'b0;
        if (!en) return;
        r    = m_lfsr;
        step = int'(spd) + 1;
        ok   = 1'b1;
        tgt  = -1;
        nret = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && m_x[i] > 120) ok = 1'b0;
            if (!m_act[i] && tgt < 0) tgt = i;
        end
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (m_x[i] > step) begin
                    m_x[i] = m_x[i] - step;
                end else begin
                    m_act[i]  = 1'b0;
                    m_pass[i] = 1'b1;
                    nret++;
                end
            end
        end
        if (ok && tgt >= 0) begin
            m_act[tgt] = 1'b1;
            m_x[tgt]   = 160 + int'(r & 8'd31);
            m_y[tgt]   = r[7] ? 85 : 100;
        end
        m_score = (m_score + nret > 65535) ? 65535 : m_score + nret;
        m_lfsr  = {r[6], r[5] ^ r[7], r[4] ^ r[7], r[3] ^ r[7], r[2], r[1], r[0], r[7]};
    endtask

    function automatic snap_t model_snapshot();
        snap_t e;
        for (int i = 0; i < N; i++) begin
            e.x[i*XW +: XW] = XW'(m_x[i]);
            e.y[i*YW +: YW] = YW'(m_y[i]);
            e.a[i]          = m_act[i];
            e.p[i]          = m_pass[i];
        end
        e.s = 16'(m_score);
        return e;
    endfunction

    task automatic check_output();
        snap_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check_val("obs_x",      64'(bus.obs_x),      64'(e.x));
        check_val("obs_y",      64'(bus.obs_y),      64'(e.y));
        check_val("obs_active", 64'(bus.obs_active), 64'(e.a));
        check_val("passed",     64'(bus.passed),     64'(e.p));
        check_val("score",      64'(bus.score),      64'(e.s));
    endtask

    task automatic apply_stimulus(input logic en, input logic [1:0] spd);
        bus.enable = en;
        bus.speed  = spd;
        model_edge(en, spd);
        sb.push_back(model_snapshot());
        @(posedge slowed_clock);
        #1;
        check_output();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_active"}, 64'(bus.obs_active), 64'd0);
        check_val({tag, "_x"},      64'(bus.obs_x),      64'd0);
        check_val({tag, "_y"},      64'(bus.obs_y),      64'({7'd100, 7'd100, 7'd100}));
        check_val({tag, "_passed"}, 64'(bus.passed),     64'd0);
        check_val({tag, "_score"},  64'(bus.score),      64'd0);
    endtask

    initial begin
        int n;
        bus.enable = 1'b0;
        bus.speed  = 2'd0;
        model_reset();

        // Reset held: outputs at reset values.
        #12;
        check_reset_values("reset_hold");
        #8;
        rst_n = 1'b1;

        // First enabled edge spawns obstacle 0 at 160+29, airborne.
        apply_stimulus(1'b1, 2'd0);
        check_val("first_spawn_x",  64'(bus.obs_x[7:0]),   64'd189);
        check_val("first_spawn_y",  64'(bus.obs_y[6:0]),   64'd85);
        check_val("first_spawn_ch12_x", 64'(bus.obs_x[23:8]), 64'd0);
        check_val("first_spawn_ch12_y", 64'(bus.obs_y[20:7]), 64'({7'd100, 7'd100}));

        // Spacing: obs1 held off until obs0 presents x=120.
        n = 0;
        while (m_x[0] != 121 && n < 200) begin
            apply_stimulus(1'b1, 2'd0);
            n++;
        end
        check_val("spacing_reach_121", 64'(n < 200), 64'd1);
        check_val("spacing_x121_obs1_idle", 64'(bus.obs_active), 64'b001);
        apply_stimulus(1'b1, 2'd0);
        check_val("spacing_x120", 64'(bus.obs_x[7:0]), 64'd120);
        check_val("spacing_x120_obs1_idle", 64'(bus.obs_active), 64'b001);
        apply_stimulus(1'b1, 2'd0);
        check_val("spacing_obs1_spawned", 64'(bus.obs_active), 64'b011);
        check_val("spacing_obs0_119", 64'(bus.obs_x[7:0]), 64'd119);

        // Run obs0 down to x=4; by then all three channels are in play.
        n = 0;
        while (!(m_act[0] && m_x[0] == 4) && n < 300) begin
            apply_stimulus(1'b1, 2'd0);
            n++;
        end
        check_val("retire_reach_x4", 64'(n < 300), 64'd1);
        check_val("full_all_active", 64'(bus.obs_active), 64'b111);

        // x=4 with step 4 retires obs0.
        apply_stimulus(1'b1, 2'd3);
        check_val("retire_active0_clear", 64'(bus.obs_active[0]), 64'd0);
        check_val("retire_passed0",       64'(bus.passed[0]),     64'd1);
        check_val("retire_score1",        64'(bus.score),         64'd1);
        apply_stimulus(1'b1, 2'd0);
        check_val("retire_passed_one_cycle", 64'(bus.passed), 64'd0);

        // Channel 0 is refilled once spacing allows.
        n = 0;
        while (!m_act[0] && n < 100) begin
            apply_stimulus(1'b1, 2'd0);
            n++;
        end
        check_val("respawn_reach", 64'(n < 100), 64'd1);
        check_val("respawn_channel0", 64'(bus.obs_active), 64'b111);

        // obs1 at x=2 with step 1: moves to 1, then retires.
        n = 0;
        while (!(m_act[1] && m_x[1] == 2) && n < 300) begin
            apply_stimulus(1'b1, 2'd0);
            n++;
        end
        check_val("slow_reach_x2", 64'(n < 300), 64'd1);
        apply_stimulus(1'b1, 2'd0);
        check_val("slow_x1",        64'(bus.obs_x[15:8]),   64'd1);
        check_val("slow_x1_active", 64'(bus.obs_active[1]), 64'd1);
        apply_stimulus(1'b1, 2'd0);
        check_val("slow_retired",   64'(bus.obs_active[1]), 64'd0);
        check_val("slow_passed1",   64'(bus.passed[1]),     64'd1);
        check_val("slow_score2",    64'(bus.score),         64'd2);

        // Freeze for 10 cycles with speed wiggling, then resume.
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b0, 2'(k));
            check_val("freeze_passed_low", 64'(bus.passed), 64'd0);
        end
        for (int k = 0; k < 40; k++) begin
            apply_stimulus(1'b1, 2'(k % 4));
        end

        // Asynchronous reset between edges, then the first spawn repeats.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        sb.delete();
        #2;
        rst_n = 1'b1;
        apply_stimulus(1'b1, 2'd0);
        check_val("rerun_spawn_x", 64'(bus.obs_x[7:0]), 64'd189);
        check_val("rerun_spawn_y", 64'(bus.obs_y[6:0]), 64'd85);
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, 2'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
